// File: rtl/cpu_cfg_regfile.sv
// Management-port slave for the cell switch: Intel/Motorola host cycles,
// programmable wait states, lockable per-channel config and an ID register.
module cpu_cfg_regfile #(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 8,
  parameter int NUM_CH      = 4,
  parameter int WAIT_STATES = 2,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter logic [DATA_W-1:0] ID_VAL    = 8'hA5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     BusMode,
  input  logic                     Sel,
  input  logic                     Rd_DS,
  input  logic                     Wr_RW,
  input  logic [ADDR_W-1:0]        Addr,
  input  logic [DATA_W-1:0]        DataIn,
  output logic [DATA_W-1:0]        DataOut,
  output logic                     Rdy_Dtack,
  output logic [NUM_CH*DATA_W-1:0] cfg,
  output logic [NUM_CH-1:0]        cfg_upd
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK
  } state_t;

  localparam logic [ADDR_W-1:0] LOCK_A = ADDR_W'(NUM_CH);
  localparam logic [ADDR_W-1:0] ID_A   = ADDR_W'(NUM_CH + 1);

  state_t              state;
  state_t              stateNext;
  logic [3:0]          cnt;
  logic                modeQ;
  logic                readQ;
  logic [ADDR_W-1:0]   addrQ;
  logic [DATA_W-1:0]   dataQ;
  logic                lockQ;
  logic [DATA_W-1:0]   dataOutQ;
  logic [NUM_CH-1:0]   updQ;
  logic [DATA_W-1:0]   cfgReg [NUM_CH];

  logic                startCyc;
  logic                startRead;
  logic                held;
  logic                goAck;
  logic                isLock;
  logic                isId;
  logic [NUM_CH-1:0]   hitCfg;
  logic [NUM_CH-1:0]   updNext;
  logic [DATA_W-1:0]   rdData;
  logic                modeEff;
  logic                ack;

  // Intel needs exactly one strobe low; both low is not a cycle.
  always_comb begin
    startCyc  = !Sel && (BusMode ? (Rd_DS ^ Wr_RW) : !Rd_DS);
    startRead = BusMode ? !Rd_DS : Wr_RW;
    if (modeQ) begin
      held = !Sel && (readQ ? !Rd_DS : !Wr_RW);
    end else begin
      held = !Sel && !Rd_DS;
    end
  end

  always_comb begin
    stateNext = state;
    goAck     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (startCyc) begin
          stateNext = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!held) begin
          stateNext = S_IDLE;
        end else if (cnt == 4'd0) begin
          stateNext = S_ACK;
          goAck     = 1'b1;
        end
      end
      S_ACK: begin
        if (!held) begin
          stateNext = S_IDLE;
        end
      end
      default: stateNext = S_IDLE;
    endcase
  end

  always_comb begin
    isLock  = (addrQ == LOCK_A);
    isId    = (addrQ == ID_A);
    hitCfg  = '0;
    updNext = '0;
    rdData  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      hitCfg[i]  = (addrQ == ADDR_W'(i));
      updNext[i] = goAck && !readQ && !lockQ && hitCfg[i];
      if (hitCfg[i]) begin
        rdData = cfgReg[i];
      end
    end
    unique case (1'b1)
      isLock:  rdData = DATA_W'(lockQ);
      isId:    rdData = ID_VAL;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      modeQ    <= 1'b0;
      readQ    <= 1'b0;
      addrQ    <= '0;
      dataQ    <= '0;
      lockQ    <= 1'b0;
      dataOutQ <= '0;
      updQ     <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        cfgReg[i] <= RESET_VAL;
      end
    end else begin
      state <= stateNext;
      updQ  <= updNext;
      if (state == S_IDLE && startCyc) begin
        modeQ <= BusMode;
        readQ <= startRead;
        addrQ <= Addr;
        dataQ <= DataIn;
        cnt   <= 4'(WAIT_STATES);
      end else if (state == S_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (updNext[i]) begin
          cfgReg[i] <= dataQ;
        end
      end
      if (goAck && !readQ && isLock) begin
        lockQ <= dataQ[0];
      end
      if (goAck && readQ) begin
        dataOutQ <= rdData;
      end
    end
  end

  // Idle follows the live bus mode so the inactive level is right before any cycle.
  always_comb begin
    ack       = (state == S_ACK);
    modeEff   = (state == S_IDLE) ? BusMode : modeQ;
    Rdy_Dtack = modeEff ? ack : !ack;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_cfg
    assign cfg[i*DATA_W +: DATA_W] = cfgReg[i];
  end

  assign DataOut = dataOutQ;
  assign cfg_upd = updQ;

endmodule

// File: tb/tb_cpu_cfg_regfile.sv
// Scoreboard bench for cpu_cfg_regfile: driver queues expected acks,
// negedge monitor pops and compares on each new ack.
module tb_cpu_cfg_regfile;
  localparam int WS = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        BusMode = 1'b1;
  logic        Sel = 1'b1;
  logic        Rd_DS = 1'b1;
  logic        Wr_RW = 1'b1;
  logic [11:0] Addr = '0;
  logic [7:0]  DataIn = '0;
  logic [7:0]  DataOut;
  logic        Rdy_Dtack;
  logic [31:0] cfg;
  logic [3:0]  cfg_upd;

  cpu_cfg_regfile #(
    .ADDR_W(12), .DATA_W(8), .NUM_CH(4), .WAIT_STATES(WS),
    .RESET_VAL(8'h00), .ID_VAL(8'hA5)
  ) dut (
    .clk(clk), .rst(rst), .BusMode(BusMode), .Sel(Sel),
    .Rd_DS(Rd_DS), .Wr_RW(Wr_RW), .Addr(Addr), .DataIn(DataIn),
    .DataOut(DataOut), .Rdy_Dtack(Rdy_Dtack), .cfg(cfg),
    .cfg_upd(cfg_upd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [7:0]  d;
    logic [3:0]  u;
    logic [31:0] c;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   ackCnt = 0;
  bit   prevAck = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    bit ackNow;
    ackNow = BusMode ? Rdy_Dtack : !Rdy_Dtack;
    if (!rst && ackNow && !prevAck) begin
      ackCnt++;
      if (q.size() == 0) begin
        chk("unexpected_ack", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("ack_cycle", 32'(cyc), 32'(e.cyc));
        chk("DataOut", 32'(DataOut), 32'(e.d));
        chk("cfg_upd", 32'(cfg_upd), 32'(e.u));
        chk("cfg", cfg, e.c);
      end
    end else if (!rst && ackNow && prevAck) begin
      chk("upd_pulse_width", 32'(cfg_upd), 32'd0);
    end
    prevAck = ackNow;
  end

  task automatic busCycle(input bit mode, input bit rd,
                          input logic [11:0] a, input logic [7:0] wd,
                          input logic [7:0] ed, input logic [3:0] eu,
                          input logic [31:0] ec, input bit rstInAck = 1'b0);
    int   start;
    exp_t e;
    @(negedge clk);
    BusMode = mode;
    Sel     = 1'b0;
    Addr    = a;
    DataIn  = wd;
    if (mode) begin
      Rd_DS = !rd;
      Wr_RW = rd;
    end else begin
      Rd_DS = 1'b0;
      Wr_RW = rd;
    end
    e.cyc = cyc + 2 + WS;
    e.d   = ed;
    e.u   = eu;
    e.c   = ec;
    q.push_back(e);
    start = ackCnt;
    for (int i = 0; i < 20 && ackCnt == start; i++) @(posedge clk);
    if (ackCnt == start) begin
      chk("ack_timeout", 32'd0, 32'd1);
      q.delete();
    end
    @(negedge clk);
    if (rstInAck) begin
      rst = 1'b1;
      @(negedge clk);
      chk("rst_rdy", 32'(Rdy_Dtack), 32'd0);
      chk("rst_cfg", cfg, 32'h0);
      chk("rst_dout", 32'(DataOut), 32'd0);
      chk("rst_upd", 32'(cfg_upd), 32'd0);
      rst = 1'b0;
    end
    Sel   = 1'b1;
    Rd_DS = 1'b1;
    Wr_RW = 1'b1;
    @(negedge clk);
    chk("ack_release", 32'(Rdy_Dtack), mode ? 32'd0 : 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bit quiet;
    repeat (2) @(negedge clk);
    chk("reset_rdy_intel", 32'(Rdy_Dtack), 32'd0);
    chk("reset_cfg", cfg, 32'h0);
    chk("reset_dout", 32'(DataOut), 32'd0);
    chk("reset_upd", 32'(cfg_upd), 32'd0);
    BusMode = 1'b0;
    @(negedge clk);
    chk("reset_dtack_moto", 32'(Rdy_Dtack), 32'd1);
    BusMode = 1'b1;
    rst = 1'b0;

    // mode rd addr wdata | DataOut upd cfg
    busCycle(1, 0, 12'h002, 8'h3C, 8'h00, 4'b0100, 32'h003C0000);
    busCycle(0, 1, 12'h002, 8'h00, 8'h3C, 4'b0000, 32'h003C0000);
    busCycle(1, 0, 12'h000, 8'h5A, 8'h3C, 4'b0001, 32'h003C005A);
    busCycle(0, 0, 12'h003, 8'h81, 8'h3C, 4'b1000, 32'h813C005A);
    busCycle(1, 1, 12'h005, 8'h00, 8'hA5, 4'b0000, 32'h813C005A);
    busCycle(1, 1, 12'h100, 8'h00, 8'h00, 4'b0000, 32'h813C005A);
    busCycle(1, 0, 12'h100, 8'h77, 8'h00, 4'b0000, 32'h813C005A);
    busCycle(1, 0, 12'h004, 8'h01, 8'h00, 4'b0000, 32'h813C005A);
    busCycle(1, 0, 12'h000, 8'hFF, 8'h00, 4'b0000, 32'h813C005A);
    busCycle(0, 1, 12'h004, 8'h00, 8'h01, 4'b0000, 32'h813C005A);
    busCycle(1, 0, 12'h004, 8'hFE, 8'h01, 4'b0000, 32'h813C005A);
    busCycle(1, 1, 12'h004, 8'h00, 8'h00, 4'b0000, 32'h813C005A);
    busCycle(0, 0, 12'h001, 8'hC3, 8'h00, 4'b0010, 32'h813CC35A);
    busCycle(1, 1, 12'h001, 8'h00, 8'hC3, 4'b0000, 32'h813CC35A);

    // Write strobe released one cycle after the start
    @(negedge clk);
    BusMode = 1'b1;
    Sel     = 1'b0;
    Addr    = 12'h000;
    DataIn  = 8'h11;
    Wr_RW   = 1'b0;
    @(negedge clk);
    Sel   = 1'b1;
    Wr_RW = 1'b1;
    quiet = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (Rdy_Dtack || cfg_upd != 4'd0) quiet = 1'b0;
    end
    chk("abort_no_ack", 32'(quiet), 32'd1);
    chk("abort_cfg", cfg, 32'h813CC35A);

    // Intel with both strobes low
    @(negedge clk);
    Sel    = 1'b0;
    Addr   = 12'h001;
    DataIn = 8'h00;
    Rd_DS  = 1'b0;
    Wr_RW  = 1'b0;
    quiet  = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (Rdy_Dtack || cfg_upd != 4'd0) quiet = 1'b0;
    end
    Sel   = 1'b1;
    Rd_DS = 1'b1;
    Wr_RW = 1'b1;
    @(negedge clk);
    chk("both_low_no_ack", 32'(quiet), 32'd1);
    chk("both_low_cfg", cfg, 32'h813CC35A);
    chk("both_low_dout", 32'(DataOut), 32'h000000C3);

    // Lock, then reset during the ack of a locked write
    busCycle(1, 0, 12'h004, 8'h01, 8'hC3, 4'b0000, 32'h813CC35A);
    busCycle(1, 0, 12'h002, 8'h99, 8'hC3, 4'b0000, 32'h813CC35A, 1'b1);
    busCycle(0, 1, 12'h004, 8'h00, 8'h00, 4'b0000, 32'h00000000);
    busCycle(1, 0, 12'h000, 8'h42, 8'h00, 4'b0001, 32'h00000042);

    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
